// File: rtl/operand_stack.sv
// Operand stack and stack pointer for the single-cycle stack machine.
// Commits one write-back plus one SP update per retired instruction.
module operand_stack #(
  parameter int REG_BITS = 32,
  parameter int DEPTH    = 16,
  localparam int SPW     = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  input  logic [1:0]          StackWriteSrc,
  input  logic [1:0]          StackUpdateMode,
  input  logic [REG_BITS-1:0] alu_result,
  input  logic [REG_BITS-1:0] dmem_rdata,
  input  logic [REG_BITS-1:0] pc_temp,
  output logic [REG_BITS-1:0] tos,
  output logic [REG_BITS-1:0] nos,
  output logic [SPW-1:0]      sp,
  output logic                overflow,
  output logic                underflow,
  output logic                halted
);

  localparam int AW = $clog2(DEPTH);
  localparam logic signed [SPW:0] DEPTH_S = (SPW+1)'(DEPTH);

  logic [REG_BITS-1:0] mem [DEPTH];

  logic signed [SPW:0] sp_ext;
  logic signed [SPW:0] new_sp;
  logic signed [SPW:0] wr_pos;
  logic [AW-1:0]       wa;
  logic [AW-1:0]       ta;
  logic [AW-1:0]       na;
  logic [REG_BITS-1:0] wdata;
  logic                do_write;
  logic                active;
  logic                ovf_hit;
  logic                unf_hit;
  logic                commit;

  assign sp_ext   = $signed({1'b0, sp});
  assign do_write = (StackWriteSrc != 2'b00);
  assign active   = instr_valid && !halted;

  always_comb begin
    new_sp = sp_ext;
    unique case (StackUpdateMode)
      2'b00: new_sp = sp_ext;
      2'b01: new_sp = sp_ext + (SPW+1)'(1);
      2'b10: new_sp = sp_ext - (SPW+1)'(2);
      2'b11: new_sp = sp_ext - (SPW+1)'(1);
      default: new_sp = sp_ext;
    endcase
  end

  always_comb begin
    wdata = alu_result;
    unique case (StackWriteSrc)
      2'b01: wdata = alu_result;
      2'b10: wdata = dmem_rdata;
      2'b11: wdata = pc_temp;
      default: wdata = alu_result;
    endcase
  end

  // Result always lands on the new top of stack.
  assign wr_pos  = new_sp - (SPW+1)'(1);
  assign wa      = wr_pos[AW-1:0];
  assign ovf_hit = active && (new_sp > DEPTH_S);
  assign unf_hit = active && !ovf_hit
                 && (new_sp[SPW] || (do_write && new_sp == '0));
  assign commit  = active && !ovf_hit && !unf_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (commit)  sp        <= new_sp[SPW-1:0];
      if (ovf_hit) overflow  <= 1'b1;
      if (unf_hit) underflow <= 1'b1;
    end
  end

  // Storage is not reset; reads are gated by sp.
  always_ff @(posedge clk) begin
    if (rst_n && commit && do_write)
      mem[wa] <= wdata;
  end

  assign ta     = AW'(sp - SPW'(1));
  assign na     = AW'(sp - SPW'(2));
  assign tos    = (sp >= SPW'(1)) ? mem[ta] : '0;
  assign nos    = (sp >= SPW'(2)) ? mem[na] : '0;
  assign halted = overflow | underflow;

endmodule

// File: tb/tb_operand_stack.sv
// Directed checks for operand_stack: push/pop, call/return,
// overflow/underflow halting and asynchronous reset.
module tb_operand_stack;

  localparam int RB  = 32;
  localparam int DP  = 16;
  localparam int SPW = $clog2(DP) + 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           instr_valid;
  logic [1:0]     StackWriteSrc;
  logic [1:0]     StackUpdateMode;
  logic [RB-1:0]  alu_result;
  logic [RB-1:0]  dmem_rdata;
  logic [RB-1:0]  pc_temp;
  logic [RB-1:0]  tos;
  logic [RB-1:0]  nos;
  logic [SPW-1:0] sp;
  logic           overflow;
  logic           underflow;
  logic           halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_stack #(.REG_BITS(RB), .DEPTH(DP)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .instr_valid(instr_valid),
    .StackWriteSrc(StackWriteSrc),
    .StackUpdateMode(StackUpdateMode),
    .alu_result(alu_result),
    .dmem_rdata(dmem_rdata),
    .pc_temp(pc_temp),
    .tos(tos),
    .nos(nos),
    .sp(sp),
    .overflow(overflow),
    .underflow(underflow),
    .halted(halted)
  );

  task automatic check(input string tag, input logic [RB-1:0] obs,
                       input logic [RB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [1:0] src,
                      input logic [1:0] mode, input logic [RB-1:0] alu,
                      input logic [RB-1:0] dm, input logic [RB-1:0] pc);
    instr_valid     = v;
    StackWriteSrc   = src;
    StackUpdateMode = mode;
    alu_result      = alu;
    dmem_rdata      = dm;
    pc_temp         = pc;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic push(input logic [RB-1:0] v);
    step(1'b1, 2'b01, 2'b01, v, '0, '0);
  endtask

  task automatic flags(input string tag, input logic o, input logic u);
    check({tag, "_ovf"}, RB'(overflow), RB'(o));
    check({tag, "_unf"}, RB'(underflow), RB'(u));
    check({tag, "_halt"}, RB'(halted), RB'(o | u));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    instr_valid = 1'b0;
    StackWriteSrc = 2'b00;
    StackUpdateMode = 2'b00;
    alu_result = '0;
    dmem_rdata = '0;
    pc_temp = '0;
    #2;
    check("rst_sp", RB'(sp), 0);
    check("rst_tos", tos, 0);
    check("rst_nos", nos, 0);
    flags("rst", 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // push-imm x3
    push(5);
    push(7);
    push(9);
    check("p3_sp", RB'(sp), 3);
    check("p3_tos", tos, 9);
    check("p3_nos", nos, 7);
    flags("p3", 1'b0, 1'b0);

    // binary op
    step(1'b1, 2'b01, 2'b11, 16, '0, '0);
    check("bin_sp", RB'(sp), 2);
    check("bin_tos", tos, 16);
    check("bin_nos", nos, 5);

    // call then return
    step(1'b1, 2'b11, 2'b01, '0, '0, 32'h40);
    check("call_sp", RB'(sp), 3);
    check("call_tos", tos, 32'h40);
    check("call_nos", nos, 16);
    step(1'b1, 2'b00, 2'b11, '0, '0, '0);
    check("ret_sp", RB'(sp), 2);
    check("ret_tos", tos, 16);

    // unary load replaces top
    step(1'b1, 2'b10, 2'b00, 32'h1, 32'hAB, '0);
    check("ld_sp", RB'(sp), 2);
    check("ld_tos", tos, 32'hAB);
    check("ld_nos", nos, 5);

    // branch pops two, no write
    step(1'b1, 2'b00, 2'b10, '0, '0, '0);
    check("br_sp", RB'(sp), 0);
    check("br_tos", tos, 0);
    check("br_nos", nos, 0);
    flags("br", 1'b0, 1'b0);

    // not valid -> no change
    step(1'b0, 2'b01, 2'b01, 32'h99, '0, '0);
    check("nv_sp", RB'(sp), 0);
    check("nv_tos", tos, 0);

    // fill to DEPTH
    for (int i = 0; i < DP; i++) push(32'h100 + i);
    check("full_sp", RB'(sp), DP);
    check("full_tos", tos, 32'h10F);
    check("full_nos", nos, 32'h10E);
    flags("full", 1'b0, 1'b0);

    // binary op at full is legal
    step(1'b1, 2'b01, 2'b11, 32'hF00, '0, '0);
    check("fbin_sp", RB'(sp), DP - 1);
    check("fbin_tos", tos, 32'hF00);
    check("fbin_nos", nos, 32'h10D);
    push(32'h1AA);
    check("refill_sp", RB'(sp), DP);

    // overflow
    push(32'hDEAD);
    check("ovf_sp", RB'(sp), DP);
    check("ovf_tos", tos, 32'h1AA);
    flags("ovf", 1'b1, 1'b0);
    push(32'hBEEF);
    step(1'b1, 2'b00, 2'b11, '0, '0, '0);
    check("ovf_ign_sp", RB'(sp), DP);
    check("ovf_ign_tos", tos, 32'h1AA);
    flags("ovf_ign", 1'b1, 1'b0);

    // async reset while halted, mid-cycle
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_sp", RB'(sp), 0);
    check("arst_tos", tos, 0);
    flags("arst", 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // underflow: binary op at sp=1
    push(32'h55);
    step(1'b1, 2'b01, 2'b11, 32'h77, '0, '0);
    check("ubin_sp", RB'(sp), 1);
    check("ubin_tos", tos, 32'h55);
    flags("ubin", 1'b0, 1'b1);
    push(32'h12);
    check("ubin_ign_sp", RB'(sp), 1);

    // underflow: branch at sp=1
    do_reset();
    flags("rst2", 1'b0, 1'b0);
    push(32'h66);
    step(1'b1, 2'b00, 2'b10, '0, '0, '0);
    check("ubr_sp", RB'(sp), 1);
    check("ubr_tos", tos, 32'h66);
    flags("ubr", 1'b0, 1'b1);

    // boundary: push at sp=0 legal
    do_reset();
    push(32'h31);
    check("p0_sp", RB'(sp), 1);
    check("p0_tos", tos, 32'h31);
    check("p0_nos", nos, 0);
    flags("p0", 1'b0, 1'b0);

    // reset at sp=5 with a pending push discarded
    for (int i = 0; i < 4; i++) push(32'h200 + i);
    check("s5_sp", RB'(sp), 5);
    instr_valid = 1'b1;
    StackWriteSrc = 2'b01;
    StackUpdateMode = 2'b01;
    alu_result = 32'h333;
    #1;
    rst_n = 1'b0;
    #1;
    check("mrst_sp", RB'(sp), 0);
    check("mrst_tos", tos, 0);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    check("mrst_hold_sp", RB'(sp), 0);
    rst_n = 1'b1;
    #1;
    check("mrst_rel_sp", RB'(sp), 0);
    flags("mrst", 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
